// File: rtl/fifo_read_packer_pkg.sv
// -----------------------------------------------------------------------------
// fifo_read_packer_pkg
// Constants shared by the synchronous FIFO and its read-side packer, plus the
// packer state type.
// -----------------------------------------------------------------------------
package fifo_read_packer_pkg;

    localparam int FIFO_WIDTH    = 16;             // FIFO word width
    localparam int FIFO_DEPTH    = 16;             // FIFO entries
    localparam int max_fifo_addr = FIFO_DEPTH - 1; // highest FIFO address
    localparam int RDPK_PACK     = 2;              // FIFO words per output beat
    localparam int RDPK_CNT_W    = 8;              // underflow counter width

    typedef enum logic {
        FILL = 1'b0,   // gathering words from the FIFO
        SEND = 1'b1    // holding a beat until the consumer takes it
    } rdpk_state_e;

endpackage

// File: rtl/fifo_read_packer_if.sv
// -----------------------------------------------------------------------------
// fifo_read_packer_if
// Bundles the FIFO read port and the wide output stream of the packer.
//   master : the packer  (drives fifo_rd_en and the out_* beat)
//   slave  : environment (drives FIFO data/flags, flush and out_ready)
// Signals:
//   fifo_rd_en      read strobe to FIFO
//   fifo_dout       FIFO data, valid one cycle after rd_en is sampled
//   fifo_empty      FIFO empty flag
//   fifo_underflow  FIFO underflow flag
//   flush           request to emit a partially filled beat
//   out_data        packed beat, lane 0 = LSBs = oldest word
//   out_keep        per-lane valid mask
//   out_valid       beat valid
//   out_ready       consumer accepts beat
// -----------------------------------------------------------------------------
interface fifo_read_packer_if
    import fifo_read_packer_pkg::*;
#(
    parameter int WIDTH = FIFO_WIDTH,
    parameter int PACK  = RDPK_PACK
);
    logic                    fifo_rd_en;
    logic [WIDTH-1:0]        fifo_dout;
    logic                    fifo_empty;
    logic                    fifo_underflow;
    logic                    flush;
    logic [WIDTH*PACK-1:0]   out_data;
    logic [PACK-1:0]         out_keep;
    logic                    out_valid;
    logic                    out_ready;

    modport master (
        output fifo_rd_en, out_data, out_keep, out_valid,
        input  fifo_dout, fifo_empty, fifo_underflow, flush, out_ready
    );

    modport slave (
        input  fifo_rd_en, out_data, out_keep, out_valid,
        output fifo_dout, fifo_empty, fifo_underflow, flush, out_ready
    );
endinterface

// File: rtl/fifo_read_packer_sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
// Event counter that counts up on every cycle i_inc is high and sticks at its
// all-ones value. Cleared only by reset.
// Ports:
//   clk      clock
//   rst      asynchronous active-high reset
//   i_inc    count-enable for this cycle
//   o_count  current count
// -----------------------------------------------------------------------------
module sat_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_inc,
    output logic [CNT_W-1:0] o_count
);
    logic [CNT_W-1:0] r_count;

    // NOTE: clocked state uses non-blocking assignments so every flop samples
    // pre-edge values, regardless of block ordering in the simulator.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_inc && (r_count != '1)) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign o_count = r_count;
endmodule

// File: rtl/fifo_read_packer.sv
// -----------------------------------------------------------------------------
// fifo_read_packer
// Pops WIDTH-bit words from a synchronous FIFO and packs PACK consecutive words
// into one wide beat on a valid/ready stream. Never reads an empty FIFO. A
// flush emits a partially filled beat with the unfilled lanes zeroed.
// Ports:
//   clk         clock, all logic on posedge
//   rst         asynchronous active-high reset
//   bus         fifo_read_packer_if.master (FIFO read port + output stream)
//   o_uf_count  saturating count of cycles with fifo_underflow high
//   o_busy      partial beat held, read in flight, or beat waiting
// -----------------------------------------------------------------------------
module fifo_read_packer
    import fifo_read_packer_pkg::*;
#(
    parameter int WIDTH = FIFO_WIDTH,
    parameter int PACK  = RDPK_PACK,
    parameter int CNT_W = RDPK_CNT_W
) (
    input  logic                clk,
    input  logic                rst,
    fifo_read_packer_if.master  bus,
    output logic [CNT_W-1:0]    o_uf_count,
    output logic                o_busy
);
    localparam int                IDX_W    = $clog2(PACK + 1);
    localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(PACK - 1);

    rdpk_state_e       r_state;
    rdpk_state_e       w_state_nxt;
    logic [IDX_W-1:0]  r_idx;          // lanes filled so far
    logic              r_rd_pend;      // FIFO data arrives this cycle
    logic              r_flush_req;    // flush accepted, waiting for data to land
    logic [PACK-1:0]   r_keep;
    logic [WIDTH-1:0]  r_lane [PACK];

    logic              w_flush_hit;
    logic              w_flush_act;
    logic              w_rd_en;
    logic              w_capture_last;
    logic              w_go_flush;
    logic [PACK-1:0]   w_keep_partial;

    // A flush only counts when there is something to emit.
    assign w_flush_hit = bus.flush && ((r_idx != '0) || r_rd_pend);
    assign w_flush_act = r_flush_req || w_flush_hit;

    // Reads stop as soon as the in-flight word would complete the beat, so at
    // most one read is outstanding. rst gates the strobe so it drops the
    // moment reset asserts, not at the next edge.
    assign w_rd_en = !rst && (r_state == FILL) && !bus.fifo_empty
                     && ((int'(r_idx) + int'(r_rd_pend)) < PACK)
                     && !w_flush_act;

    assign w_capture_last = (r_state == FILL) && r_rd_pend && (r_idx == IDX_LAST);
    assign w_go_flush     = (r_state == FILL) && w_flush_act && !r_rd_pend
                            && (r_idx != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= FILL;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // NOTE: every variable written here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            FILL:    if (w_capture_last || w_go_flush) w_state_nxt = SEND;
            SEND:    if (bus.out_ready)                w_state_nxt = FILL;
            default: w_state_nxt = FILL;
        endcase
    end

    always_comb begin
        w_keep_partial = '0;
        for (int i = 0; i < PACK; i++) begin
            w_keep_partial[i] = (int'(r_idx) > i);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idx       <= '0;
            r_rd_pend   <= 1'b0;
            r_flush_req <= 1'b0;
            r_keep      <= '0;
        end else begin
            r_rd_pend <= w_rd_en;
            if (r_state == SEND) begin
                if (bus.out_ready) begin
                    r_idx       <= '0;
                    r_keep      <= '0;
                    r_flush_req <= 1'b0;
                end
            end else begin
                // A flush arriving with the very first read is kept, so that
                // word is emitted alone once it lands.
                if (bus.flush && ((r_idx != '0) || r_rd_pend || w_rd_en)) begin
                    r_flush_req <= 1'b1;
                end
                if (r_rd_pend) begin
                    r_idx <= r_idx + IDX_W'(1);
                end
                if (w_capture_last) begin
                    r_keep <= '1;
                end else if (w_go_flush) begin
                    r_keep <= w_keep_partial;
                end
            end
        end
    end

    // NOTE: the lane storage has no reset; out_keep is cleared by reset and
    // masks every lane, so stale contents can never reach out_data.
    always_ff @(posedge clk) begin
        if ((r_state == FILL) && r_rd_pend) begin
            for (int i = 0; i < PACK; i++) begin
                if (r_idx == IDX_W'(i)) r_lane[i] <= bus.fifo_dout;
            end
        end
    end

    always_comb begin
        bus.out_data = '0;
        for (int i = 0; i < PACK; i++) begin
            if (r_keep[i]) bus.out_data[i*WIDTH +: WIDTH] = r_lane[i];
        end
    end

    assign bus.fifo_rd_en = w_rd_en;
    assign bus.out_keep   = r_keep;
    assign bus.out_valid  = (r_state == SEND);
    assign o_busy         = (r_idx != '0) || r_rd_pend || (r_state == SEND);

    sat_counter #(.CNT_W(CNT_W)) u_uf_cnt (
        .clk     (clk),
        .rst     (rst),
        .i_inc   (bus.fifo_underflow),
        .o_count (o_uf_count)
    );

    // Safety properties: never read an empty FIFO; a stalled beat holds still.
    a_no_read_when_empty: assert property (@(posedge clk) disable iff (rst)
        !(bus.fifo_rd_en && bus.fifo_empty));

    a_beat_stable: assert property (@(posedge clk) disable iff (rst)
        (bus.out_valid && !bus.out_ready) |=>
        (bus.out_valid && $stable(bus.out_data) && $stable(bus.out_keep)));
endmodule

// File: tb/tb_fifo_read_packer.sv
`timescale 1ns/1ps
module tb_fifo_read_packer;
    import fifo_read_packer_pkg::*;

    localparam int W  = 16;
    localparam int P  = 2;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [CW-1:0] uf_count;
    logic [1:0]    uf2;
    logic          busy;

    always #5 clk = ~clk;

    fifo_read_packer_if #(.WIDTH(W), .PACK(P)) bus ();

    fifo_read_packer #(.WIDTH(W), .PACK(P), .CNT_W(CW)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .o_uf_count (uf_count),
        .o_busy     (busy)
    );

    // Narrow counter on the same underflow flag, for the saturation case.
    sat_counter #(.CNT_W(2)) u_sat2 (
        .clk     (clk),
        .rst     (rst),
        .i_inc   (bus.fifo_underflow),
        .o_count (uf2)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int n_rd     = 0;   // rd_en pulses seen from the DUT
    int n_beats  = 0;   // beats handed over (valid & ready) by the DUT

    logic [W-1:0] fq[$];   // emulated FIFO contents

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model, evaluated mid-cycle ----------------
    logic [W-1:0] m_words[$];  // words already landed in the current beat
    bit           m_pend;      // a read was issued last cycle
    bit           m_send;      // a beat is being offered
    bit           m_flreq;     // flush accepted
    int           m_uf;
    int           m_uf2;

    always @(negedge clk) begin : model
        int              sz;
        logic            exp_rd;
        logic            fl_hit;
        logic            go_flush;
        logic [P-1:0]    exp_keep;
        logic [W*P-1:0]  exp_data;

        if (rst) begin
            m_words.delete();
            m_pend  = 1'b0;
            m_send  = 1'b0;
            m_flreq = 1'b0;
            m_uf    = 0;
            m_uf2   = 0;
        end
        sz       = m_words.size();
        fl_hit   = bus.flush && (sz > 0 || m_pend);
        exp_rd   = !rst && !m_send && !bus.fifo_empty && (sz + int'(m_pend) < P)
                   && !(m_flreq || fl_hit);
        exp_keep = '0;
        exp_data = '0;
        if (m_send) begin
            for (int i = 0; i < sz; i++) begin
                exp_keep[i]          = 1'b1;
                exp_data[i*W +: W]   = m_words[i];
            end
        end

        check("rd_en",       bus.fifo_rd_en, exp_rd);
        check("out_valid",   bus.out_valid,  m_send);
        check("out_keep",    bus.out_keep,   exp_keep);
        check("out_data",    bus.out_data,   exp_data);
        check("busy",        busy,           (sz > 0) || m_pend || m_send);
        check("uf_count",    uf_count,       m_uf);
        check("uf_count_w2", uf2,            m_uf2);

        if (bus.fifo_rd_en) n_rd++;
        if (bus.out_valid && bus.out_ready) n_beats++;

        if (!rst) begin
            if (bus.fifo_underflow) begin
                if (m_uf < 255) m_uf++;
                if (m_uf2 < 3) m_uf2++;
            end
            if (m_send) begin
                if (bus.out_ready) begin
                    m_words.delete();
                    m_send  = 1'b0;
                    m_flreq = 1'b0;
                end
            end else begin
                go_flush = (m_flreq || fl_hit) && !m_pend && sz > 0;
                if (bus.flush && (sz > 0 || m_pend || exp_rd)) m_flreq = 1'b1;
                if (m_pend) m_words.push_back(bus.fifo_dout);
                if (m_words.size() == P || go_flush) m_send = 1'b1;
            end
            m_pend = exp_rd;
        end
    end

    // ---------------- stimulus helpers ----------------
    // Advance one clock; the emulated FIFO pops if the DUT read this cycle.
    task automatic tick();
        logic rd;
        @(negedge clk);
        rd = bus.fifo_rd_en;
        @(posedge clk);
        #1;
        if (rd && fq.size() > 0) bus.fifo_dout = fq.pop_front();
        bus.fifo_empty = (fq.size() == 0);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic push(input logic [W-1:0] w);
        fq.push_back(w);
        bus.fifo_empty = 1'b0;
    endtask

    task automatic assert_rst();
        rst = 1'b1;
        fq.delete();
        bus.fifo_empty = 1'b1;
    endtask

    task automatic wait_valid(input string name, input int budget);
        int k = 0;
        while (!bus.out_valid && k < budget) begin
            tick();
            k++;
        end
        check({name, "_timeout"}, bus.out_valid, 1'b1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got running, expected done");
        $fatal(1);
    end

    initial begin
        int rd0;
        int b0;

        bus.fifo_dout      = '0;
        bus.fifo_empty     = 1'b1;
        bus.fifo_underflow = 1'b0;
        bus.flush          = 1'b0;
        bus.out_ready      = 1'b0;
        ticks(3);
        check("rst_valid", bus.out_valid,  0);
        check("rst_keep",  bus.out_keep,   0);
        check("rst_data",  bus.out_data,   0);
        check("rst_busy",  busy,           0);
        check("rst_uf",    uf_count,       0);
        rst = 1'b0;

        // 1: two words -> one full beat
        rd0 = n_rd; b0 = n_beats;
        bus.out_ready = 1'b1;
        push(16'h1111); push(16'h2222);
        wait_valid("t1", 10);
        check("t1_data", bus.out_data, 32'h2222_1111);
        check("t1_keep", bus.out_keep, 2'b11);
        ticks(3);
        check("t1_rd_pulses", n_rd - rd0, 2);
        check("t1_beats",     n_beats - b0, 1);
        check("t1_uf",        uf_count, 0);

        // 2: back-pressure holds the first beat, then the rest drains in order
        bus.out_ready = 1'b0;
        rd0 = n_rd; b0 = n_beats;
        for (int i = 0; i < 8; i++) push(16'h0100 + 16'(i));
        ticks(10);
        check("t2_rd_hold",    n_rd - rd0, 2);
        check("t2_valid_hold", bus.out_valid, 1);
        check("t2_data_hold",  bus.out_data, 32'h0101_0100);
        bus.out_ready = 1'b1;
        ticks(20);
        check("t2_rd_total", n_rd - rd0, 8);
        check("t2_beats",    n_beats - b0, 4);
        check("t2_empty",    bus.fifo_empty, 1);
        check("t2_idle",     busy, 0);

        // 3: single word flushed out; flush while idle does nothing
        push(16'hABCD);
        ticks(3);
        check("t3_busy_partial", busy, 1);
        bus.flush = 1'b1; tick(); bus.flush = 1'b0;
        wait_valid("t3", 5);
        check("t3_data", bus.out_data, 32'h0000_ABCD);
        check("t3_keep", bus.out_keep, 2'b01);
        ticks(2);
        b0 = n_beats;
        bus.flush = 1'b1; tick(); bus.flush = 1'b0;
        ticks(3);
        check("t3_idle_busy",  busy, 0);
        check("t3_idle_beats", n_beats - b0, 0);

        // 4: flush together with the first read
        push(16'h5555); push(16'h6666);
        bus.flush = 1'b1; tick(); bus.flush = 1'b0;
        wait_valid("t4", 5);
        check("t4_data", bus.out_data, 32'h0000_5555);
        check("t4_keep", bus.out_keep, 2'b01);
        ticks(5);
        bus.flush = 1'b1; tick(); bus.flush = 1'b0;
        wait_valid("t4b", 5);
        check("t4b_data", bus.out_data, 32'h0000_6666);
        ticks(2);

        // 5: reset during SEND and with a read in flight
        bus.out_ready = 1'b0;
        push(16'h7777); push(16'h8888);
        wait_valid("t5", 10);
        assert_rst(); #1;
        check("t5_send_valid", bus.out_valid, 0);
        check("t5_send_keep",  bus.out_keep,  0);
        check("t5_send_busy",  busy,          0);
        ticks(2); rst = 1'b0;
        push(16'h9999); push(16'hAAAA);
        tick();
        check("t5_pend_busy", busy, 1);
        assert_rst(); #1;
        check("t5_pend_rd_en", bus.fifo_rd_en, 0);
        check("t5_pend_busy0", busy, 0);
        ticks(2); rst = 1'b0;
        bus.out_ready = 1'b1;
        push(16'hC001); push(16'hC002);
        wait_valid("t5_post", 10);
        check("t5_post_data", bus.out_data, 32'hC002_C001);
        check("t5_post_keep", bus.out_keep, 2'b11);
        ticks(2);

        // 6: underflow counting and saturation
        bus.fifo_underflow = 1'b1; ticks(3); bus.fifo_underflow = 1'b0; tick();
        check("t6_uf3",  uf_count, 3);
        check("t6_uf2a", uf2, 3);
        assert_rst(); tick(); rst = 1'b0;
        bus.fifo_underflow = 1'b1; ticks(5); bus.fifo_underflow = 1'b0; tick();
        check("t6_uf5",   uf_count, 5);
        check("t6_uf2sat", uf2, 3);
        bus.fifo_underflow = 1'b1; ticks(300); bus.fifo_underflow = 1'b0; tick();
        check("t6_uf_sat", uf_count, 255);

        // Random traffic against the model
        for (int c = 0; c < 1500; c++) begin
            if (fq.size() <= max_fifo_addr && $urandom_range(0, 2) == 0) push(16'($urandom));
            bus.out_ready      = ($urandom_range(0, 3) != 0);
            bus.flush          = ($urandom_range(0, 15) == 0);
            bus.fifo_underflow = ($urandom_range(0, 31) == 0);
            if ($urandom_range(0, 199) == 0) assert_rst();
            else rst = 1'b0;
            tick();
        end
        rst = 1'b0;
        bus.flush = 1'b0;
        bus.fifo_underflow = 1'b0;
        ticks(4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
